// File: rtl/conv_burst_tx_if.sv
// Handshake bundle between the burst transmitter, its host write port and the CONV input side.
// The master modport is the transmitter; the slave modport is the host/CONV environment.
interface conv_burst_tx_if #(
  parameter int unsigned FIFO_DEPTH = 32
);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  logic              wr_valid;
  logic              wr_ready;
  logic [2:0]        wr_data1;
  logic [2:0]        wr_data2;
  logic              in_valid;
  logic [2:0]        in_data1;
  logic [2:0]        in_data2;
  logic              resp_valid;
  logic              busy;
  logic              burst_done;
  logic              timeout_err;
  logic [CountW-1:0] fifo_count;

  modport master (
    input  wr_valid, wr_data1, wr_data2, resp_valid,
    output wr_ready, in_valid, in_data1, in_data2, busy, burst_done, timeout_err, fifo_count
  );

  modport slave (
    output wr_valid, wr_data1, wr_data2, resp_valid,
    input  wr_ready, in_valid, in_data1, in_data2, busy, burst_done, timeout_err, fifo_count
  );
endinterface

// File: rtl/conv_burst_tx.sv
// CONV input driver: buffers host operand pairs and releases them as fixed-length bursts,
// holding off the next burst until the engine has returned its responses.
module conv_burst_tx #(
  parameter int unsigned BURST_LEN  = 18,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned RESP_LEN   = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic             clk_1,
  input logic             rst,
  conv_burst_tx_if.master bus
);
  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SendW  = $clog2(BURST_LEN + 1);
  localparam int unsigned RespW  = $clog2(RESP_LEN + 1);
  localparam int unsigned WaitW  = $clog2(TIMEOUT + 1);

  localparam logic [PtrW-1:0]   PtrLast  = PtrW'(FIFO_DEPTH - 1);
  localparam logic [CountW-1:0] DepthCnt = CountW'(FIFO_DEPTH);
  localparam logic [CountW-1:0] BurstCnt = CountW'(BURST_LEN);
  localparam logic [SendW-1:0]  SendLast = SendW'(BURST_LEN - 1);
  localparam logic [RespW-1:0]  RespMax  = RespW'(RESP_LEN);
  localparam logic [WaitW-1:0]  WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSend, StWaitResp, StGap} state_e;

  state_e            state_q;
  logic [5:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic [SendW-1:0]  send_cnt_q;
  logic [RespW-1:0]  resp_cnt_q;
  logic [WaitW-1:0]  wait_cnt_q;
  logic              in_valid_q, burst_done_q, timeout_err_q;
  logic [2:0]        in_data1_q, in_data2_q;

  logic       push, pop, start, resp_hit, resp_full, wait_expired;
  logic [5:0] rd_pair;
  logic [RespW-1:0] resp_cnt_inc;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign bus.wr_ready = (count_q < DepthCnt);
  assign push         = bus.wr_valid && bus.wr_ready;
  // A burst only starts with a full burst's worth of data buffered, so SEND never starves.
  assign start        = (state_q == StIdle) && (count_q >= BurstCnt) && !timeout_err_q;
  assign pop          = start || (state_q == StSend);
  assign rd_pair      = mem_q[rd_ptr_q];

  assign resp_hit     = bus.resp_valid && ((state_q == StSend) || (state_q == StWaitResp));
  assign resp_cnt_inc = (resp_hit && (resp_cnt_q != RespMax)) ? resp_cnt_q + RespW'(1)
                                                              : resp_cnt_q;
  assign resp_full    = (resp_cnt_inc == RespMax);
  assign wait_expired = (wait_cnt_q == WaitLast);

  always_ff @(posedge clk_1) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.wr_data1, bus.wr_data2};
    end
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      send_cnt_q    <= '0;
      resp_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      in_valid_q    <= 1'b0;
      in_data1_q    <= '0;
      in_data2_q    <= '0;
      burst_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop) begin
        count_q <= count_q + CountW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CountW'(1);
      end

      in_valid_q   <= pop;
      in_data1_q   <= pop ? rd_pair[5:3] : '0;
      in_data2_q   <= pop ? rd_pair[2:0] : '0;
      burst_done_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) begin
            send_cnt_q <= SendW'(1);
            resp_cnt_q <= '0;
            wait_cnt_q <= '0;
            state_q    <= (BURST_LEN == 1) ? StWaitResp : StSend;
          end
        end
        StSend: begin
          send_cnt_q <= send_cnt_q + SendW'(1);
          resp_cnt_q <= resp_cnt_inc;
          if (send_cnt_q == SendLast) state_q <= StWaitResp;
        end
        StWaitResp: begin
          resp_cnt_q <= resp_cnt_inc;
          wait_cnt_q <= wait_cnt_q + WaitW'(1);
          // A completing response on the expiry cycle takes priority over the timeout.
          if (resp_full) begin
            burst_done_q <= 1'b1;
            state_q      <= StGap;
          end else if (wait_expired) begin
            timeout_err_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_valid    = in_valid_q;
  assign bus.in_data1    = in_data1_q;
  assign bus.in_data2    = in_data2_q;
  assign bus.busy        = (state_q == StSend) || (state_q == StWaitResp);
  assign bus.burst_done  = burst_done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.fifo_count  = count_q;
endmodule

// File: tb/tb_conv_burst_tx.sv
// Directed bench for conv_burst_tx: burst framing, thresholds, backpressure, timeout and reset.
module tb_conv_burst_tx;
  localparam int unsigned BurstLen  = 18;
  localparam int unsigned FifoDepth = 32;
  localparam int unsigned RespLen   = 4;
  localparam int unsigned Timeout   = 1024;

  logic clk_1 = 1'b0;
  logic rst   = 1'b1;

  conv_burst_tx_if #(.FIFO_DEPTH(FifoDepth)) bus ();

  conv_burst_tx #(
    .BURST_LEN (BurstLen),
    .FIFO_DEPTH(FifoDepth),
    .RESP_LEN  (RespLen),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk_1(clk_1),
    .rst  (rst),
    .bus  (bus.master)
  );

  always #5 clk_1 = ~clk_1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] pair(input int i);
    logic [2:0] a, b;
    a = 3'(i % 8);
    b = 3'(7 - (i % 8));
    return {a, b};
  endfunction

  // Output trace, sampled on the falling edge and cleared while reset is held.
  logic [5:0] data_q[$];
  int runs[$];
  int gaps[$];
  int run_len = 0, low_len = 0, done_cnt = 0, zero_bad = 0;

  always @(negedge clk_1) begin
    if (rst) begin
      data_q.delete();
      runs.delete();
      gaps.delete();
      run_len  = 0;
      low_len  = 0;
      done_cnt = 0;
    end else begin
      if (bus.in_valid) begin
        if (run_len == 0 && runs.size() > 0) gaps.push_back(low_len);
        run_len++;
        low_len = 0;
        data_q.push_back({bus.in_data1, bus.in_data2});
      end else begin
        if (run_len != 0) runs.push_back(run_len);
        run_len = 0;
        low_len++;
        if (bus.in_data1 != 3'd0 || bus.in_data2 != 3'd0) zero_bad++;
      end
      if (bus.burst_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  task automatic do_reset();
    bus.wr_valid   = 1'b0;
    bus.resp_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_pairs(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      int g;
      g = 0;
      bus.wr_valid = 1'b1;
      bus.wr_data1 = pair(i)[5:3];
      bus.wr_data2 = pair(i)[2:0];
      while (!bus.wr_ready && g < 200) begin
        tick();
        g++;
      end
      if (g >= 200) check_eq("wr_ready_wait", g, 0);
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic respond(input int bursts);
    for (int b = 0; b < bursts; b++) begin
      int g;
      g = 0;
      while (!bus.in_valid && g < 400) begin
        tick();
        g++;
      end
      while (bus.in_valid && g < 400) begin
        tick();
        g++;
      end
      if (g >= 400) check_eq("resp_wait", g, 0);
      bus.resp_valid = 1'b1;
      repeat (RespLen) tick();
      bus.resp_valid = 1'b0;
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    bus.wr_valid   = 1'b0;
    bus.wr_data1   = '0;
    bus.wr_data2   = '0;
    bus.resp_valid = 1'b0;

    // Reset state and a single burst with delayed responses.
    do_reset();
    check_eq("rst_in_valid", bus.in_valid, 0);
    check_eq("rst_in_data", {bus.in_data1, bus.in_data2}, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_burst_done", bus.burst_done, 0);
    check_eq("rst_timeout_err", bus.timeout_err, 0);
    check_eq("rst_fifo_count", bus.fifo_count, 0);
    check_eq("rst_wr_ready", bus.wr_ready, 1);

    write_pairs(0, 18);
    check_eq("t1_latency_c1", bus.in_valid, 0);
    tick();
    check_eq("t1_latency_c2", bus.in_valid, 1);
    check_eq("t1_busy", bus.busy, 1);
    n = 0;
    while (bus.in_valid && n < 100) begin
      tick();
      n++;
    end
    check_eq("t1_high_cycles", n, 18);
    repeat (4) tick();
    bus.resp_valid = 1'b1;
    repeat (4) tick();
    bus.resp_valid = 1'b0;
    check_eq("t1_done_pulse", bus.burst_done, 1);
    check_eq("t1_busy_gap", bus.busy, 0);
    tick();
    check_eq("t1_done_low", bus.burst_done, 0);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_runs", runs.size(), 1);
    check_eq("t1_run_len", runs[0], 18);
    for (int i = 0; i < 18; i++) check_eq($sformatf("t1_data%0d", i), data_q[i], pair(i));

    // Below threshold: nothing is sent until the 18th pair arrives.
    do_reset();
    write_pairs(0, 17);
    repeat (30) tick();
    check_eq("t2_no_partial", data_q.size(), 0);
    check_eq("t2_count17", bus.fifo_count, 17);
    write_pairs(17, 1);
    check_eq("t2_lat_c1", bus.in_valid, 0);
    tick();
    check_eq("t2_lat_c2", bus.in_valid, 1);
    check_eq("t2_first_data", {bus.in_data1, bus.in_data2}, pair(0));

    // Two back-to-back bursts with prompt responses.
    do_reset();
    fork
      write_pairs(0, 36);
      respond(2);
    join
    n = 0;
    while (done_cnt < 2 && n < 100) begin
      tick();
      n++;
    end
    check_eq("t4_done_cnt", done_cnt, 2);
    check_eq("t4_runs", runs.size(), 2);
    check_eq("t4_run0", runs[0], 18);
    check_eq("t4_run1", runs[1], 18);
    check_eq("t4_gap", gaps[0], 6);
    check_eq("t4_burst2_first", data_q[18], pair(18));
    check_eq("t4_burst2_last", data_q[35], pair(35));
    check_eq("t4_count", bus.fifo_count, 0);

    // Streaming writes overlap the burst, then no response arrives at all.
    do_reset();
    fork
      write_pairs(0, 32);
      begin
        int g;
        g = 0;
        while (!bus.in_valid && g < 100) begin
          tick();
          g++;
        end
        for (int k = 0; k < 10; k++) begin
          check_eq($sformatf("t3_count_stable%0d", k), bus.fifo_count, 18);
          tick();
        end
      end
    join
    check_eq("t3_count_after_writes", bus.fifo_count, 18);
    n = 0;
    while (!bus.timeout_err && n < 2000) begin
      tick();
      n++;
    end
    check_eq("t3_timeout_latency", n, 1028);
    check_eq("t3_timeout_err", bus.timeout_err, 1);
    check_eq("t3_busy", bus.busy, 0);
    check_eq("t3_count14", bus.fifo_count, 14);
    repeat (50) tick();
    check_eq("t3_no_second_burst", runs.size(), 1);
    check_eq("t3_in_valid_low", bus.in_valid, 0);
    write_pairs(32, 18);
    check_eq("t3_full_count", bus.fifo_count, 32);
    check_eq("t3_full_wr_ready", bus.wr_ready, 0);
    bus.wr_valid = 1'b1;
    repeat (3) tick();
    bus.wr_valid = 1'b0;
    check_eq("t3_no_overflow", bus.fifo_count, 32);
    check_eq("t3_err_sticky", bus.timeout_err, 1);

    // Reset on the 9th in_valid cycle truncates the burst for good.
    do_reset();
    write_pairs(0, 18);
    tick();
    repeat (8) tick();
    check_eq("t5_mid_burst", bus.in_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_in_valid", bus.in_valid, 0);
    check_eq("t5_count", bus.fifo_count, 0);
    check_eq("t5_busy", bus.busy, 0);
    check_eq("t5_timeout_err", bus.timeout_err, 0);
    fork
      write_pairs(40, 18);
      respond(1);
    join
    tick();
    check_eq("t5_done_cnt", done_cnt, 1);
    check_eq("t5_runs", runs.size(), 1);
    check_eq("t5_run_len", runs[0], 18);
    check_eq("t5_first", data_q[0], pair(40));
    check_eq("t5_last", data_q[17], pair(57));

    // The 4th response lands exactly on the timeout cycle and must win.
    do_reset();
    write_pairs(0, 18);
    tick();
    while (bus.in_valid) tick();
    bus.resp_valid = 1'b1;
    repeat (3) tick();
    bus.resp_valid = 1'b0;
    repeat (1019) tick();
    check_eq("t6_no_done_yet", bus.burst_done, 0);
    bus.resp_valid = 1'b1;
    tick();
    bus.resp_valid = 1'b0;
    check_eq("t6_done", bus.burst_done, 1);
    check_eq("t6_no_err", bus.timeout_err, 0);
    tick();
    check_eq("t6_no_err_after", bus.timeout_err, 0);

    check_eq("idle_data_zero", zero_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
